// File: rtl/d_r_bch_pkg.sv
// Shared types and defaults for the BCH decoder read-side message path.
package d_r_bch_pkg;

  localparam int unsigned ErrAddrWidth = 8;
  localparam int unsigned ErrDataWidth = 16;
  localparam int unsigned DefMsgWords  = 128;
  localparam int unsigned DefMaxErr    = 14;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic                    valid;
    logic [ErrAddrWidth-1:0] addr;
    logic [ErrDataWidth-1:0] mask;
  } err_entry_t;

  function automatic int unsigned popcount(input logic [ErrDataWidth-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < int'(ErrDataWidth); i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/d_r_message_output_ctrl_if.sv
// Buffer read port, error-load port and corrected-word stream of the message output controller.
interface d_r_message_output_ctrl_if #(
  parameter int unsigned Multi        = 2,
  parameter int unsigned AddressWidth = 8,
  parameter int unsigned DataWidth    = 16
);
  logic                          i_err_wr;
  logic [AddressWidth-1:0]       i_err_addr;
  logic [DataWidth-1:0]          i_err_mask;
  logic                          i_start;
  logic                          i_decode_fail;
  logic [Multi-1:0]              o_enb;
  logic [AddressWidth*Multi-1:0] o_addrb;
  logic [DataWidth-1:0]          i_doutb;
  logic [DataWidth-1:0]          o_data;
  logic                          o_data_valid;
  logic                          i_data_ready;
  logic                          o_data_last;
  logic                          o_c_message_output_cmplt;
  logic                          o_busy;
  logic                          o_uncorrectable;
  logic                          o_err_ovf;

  // Controller side.
  modport master (
    input  i_err_wr, i_err_addr, i_err_mask, i_start, i_decode_fail, i_doutb, i_data_ready,
    output o_enb, o_addrb, o_data, o_data_valid, o_data_last, o_c_message_output_cmplt,
           o_busy, o_uncorrectable, o_err_ovf
  );

  // Environment side: buffer, error locator and downstream consumer.
  modport slave (
    output i_err_wr, i_err_addr, i_err_mask, i_start, i_decode_fail, i_doutb, i_data_ready,
    input  o_enb, o_addrb, o_data, o_data_valid, o_data_last, o_c_message_output_cmplt,
           o_busy, o_uncorrectable, o_err_ovf
  );
endinterface

// File: rtl/d_r_output_skid_fifo.sv
// Two-entry first-word-fall-through FIFO; the head is presented from storage with no read request.
module d_r_output_skid_fifo #(
  parameter int unsigned Width = 17
) (
  input  logic             i_clk,
  input  logic             i_RESET,
  input  logic             i_push,
  input  logic [Width-1:0] i_push_data,
  input  logic             i_pop,
  output logic [Width-1:0] o_head,
  output logic             o_valid,
  output logic [1:0]       o_count
);

  logic [Width-1:0] mem_q [2];
  logic             wp_q, rp_q;
  logic [1:0]       cnt_q;
  logic             push_ok, pop_ok;

  assign pop_ok  = i_pop && (cnt_q != 2'd0);
  assign push_ok = i_push && ((cnt_q != 2'd2) || pop_ok);

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem_q[wp_q] <= i_push_data;
        wp_q        <= ~wp_q;
      end
      if (pop_ok) begin
        rp_q <= ~rp_q;
      end
      if (push_ok && !pop_ok) begin
        cnt_q <= cnt_q + 2'd1;
      end else if (pop_ok && !push_ok) begin
        cnt_q <= cnt_q - 2'd1;
      end
    end
  end

  assign o_head  = mem_q[rp_q];
  assign o_valid = (cnt_q != 2'd0);
  assign o_count = cnt_q;

endmodule

// File: rtl/d_r_message_output_ctrl.sv
// Streams one codeword's message out of the rotating buffer, XOR-applying the loaded error masks.
// Optional D_R_MSG_OUTPUT_STAT_EN adds o_corrected_bits (popcount of masks applied per message).
module d_r_message_output_ctrl
  import d_r_bch_pkg::*;
#(
  parameter int unsigned Multi        = 2,
  parameter int unsigned AddressWidth = ErrAddrWidth,
  parameter int unsigned DataWidth    = ErrDataWidth,
  parameter int unsigned MsgWords     = DefMsgWords,
  parameter int unsigned MaxErr       = DefMaxErr
) (
  input  logic                                     i_clk,
  input  logic                                     i_RESET,
`ifdef D_R_MSG_OUTPUT_STAT_EN
  output logic [$clog2(MaxErr*DataWidth+1)-1:0]    o_corrected_bits,
`endif
  d_r_message_output_ctrl_if.master                bus
);

  localparam int unsigned CntW = $clog2(MaxErr + 1);
  localparam logic [CntW-1:0]         MaxCnt  = CntW'(MaxErr);
  localparam logic [AddressWidth-1:0] LastIdx = AddressWidth'(MsgWords - 1);

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] rp_q;
  logic [AddressWidth-1:0] rd_idx_q;
  logic                    rd_pend_q;
  logic                    uncorr_q;
  logic                    ovf_q;
  err_entry_t              tbl_q [MaxErr];
  logic [CntW-1:0]         cnt_q;

  logic                    issue;
  logic [1:0]              occ;
  logic                    pop;
  logic                    push;
  logic [DataWidth-1:0]    corr_mask;
  logic [DataWidth:0]      push_data;
  logic [DataWidth:0]      head;
  logic                    fifo_valid;
  logic [1:0]              fifo_cnt;
  logic                    head_last;

  assign pop       = fifo_valid && bus.i_data_ready;
  assign head_last = head[DataWidth];

  // Buffered words plus the read in flight, net of this cycle's pop, never exceed two.
  assign occ   = fifo_cnt + {1'b0, rd_pend_q} - {1'b0, pop};
  assign issue = (state_q == StRun) && (occ < 2'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.i_start) state_d = StRun;
      StRun:   if (issue && (rp_q == LastIdx)) state_d = StDrain;
      StDrain: if (pop && head_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      state_q   <= StIdle;
      rp_q      <= '0;
      rd_idx_q  <= '0;
      rd_pend_q <= 1'b0;
      uncorr_q  <= 1'b0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      for (int i = 0; i < int'(MaxErr); i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      rd_pend_q <= issue;
      if (issue) begin
        rd_idx_q <= rp_q;
        rp_q     <= rp_q + 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          rp_q <= '0;
          // A load in the start cycle lands before the message is read.
          if (bus.i_err_wr) begin
            if (cnt_q < MaxCnt) begin
              for (int i = 0; i < int'(MaxErr); i++) begin
                if (CntW'(i) == cnt_q) begin
                  tbl_q[i].valid <= 1'b1;
                  tbl_q[i].addr  <= bus.i_err_addr;
                  tbl_q[i].mask  <= bus.i_err_mask;
                end
              end
              cnt_q <= cnt_q + 1'b1;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (bus.i_start) begin
            uncorr_q <= bus.i_decode_fail;
          end
        end
        StDone: begin
          cnt_q    <= '0;
          ovf_q    <= 1'b0;
          uncorr_q <= 1'b0;
          for (int i = 0; i < int'(MaxErr); i++) begin
            tbl_q[i] <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Full parallel compare of the returned word index; duplicate entries OR together.
  always_comb begin
    corr_mask = '0;
    for (int i = 0; i < int'(MaxErr); i++) begin
      if (tbl_q[i].valid && (tbl_q[i].addr == rd_idx_q)) begin
        corr_mask = corr_mask | tbl_q[i].mask;
      end
    end
    if (uncorr_q) begin
      corr_mask = '0;
    end
  end

  assign push      = rd_pend_q;
  assign push_data = {(rd_idx_q == LastIdx), bus.i_doutb ^ corr_mask};

  d_r_output_skid_fifo #(
    .Width (DataWidth + 1)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_RESET     (i_RESET),
    .i_push      (push),
    .i_push_data (push_data),
    .i_pop       (pop),
    .o_head      (head),
    .o_valid     (fifo_valid),
    .o_count     (fifo_cnt)
  );

  assign bus.o_enb                    = {Multi{issue}};
  assign bus.o_addrb                  = issue ? (AddressWidth*Multi)'(rp_q) : '0;
  assign bus.o_data                   = head[DataWidth-1:0];
  assign bus.o_data_valid             = fifo_valid;
  assign bus.o_data_last              = fifo_valid && head_last;
  assign bus.o_c_message_output_cmplt = (state_q == StDone);
  assign bus.o_busy                   = (state_q != StIdle);
  assign bus.o_uncorrectable          = uncorr_q;
  assign bus.o_err_ovf                = ovf_q;

`ifdef D_R_MSG_OUTPUT_STAT_EN
  localparam int unsigned CbW = $clog2(MaxErr*DataWidth+1);
  logic [CbW-1:0] cb_q;

  always_ff @(posedge i_clk or posedge i_RESET) begin
    if (i_RESET) begin
      cb_q <= '0;
    end else if ((state_q == StIdle) && bus.i_start) begin
      cb_q <= '0;
    end else if (push) begin
      cb_q <= cb_q + CbW'(popcount(corr_mask));
    end
  end

  assign o_corrected_bits = cb_q;
`endif

endmodule
